// File: rtl/bf_word_mem.sv
// Word memory with write, XOR bit-flip, registered read, tap output and a sequential clear sweep.
// Define BF_WORD_MEM_FLIP_EN to enable the flip port; otherwise flip inputs are ignored.
module bf_word_mem #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 16,
  parameter int TAP_IDX = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       flip_en,
  input  logic [$clog2(DEPTH)-1:0]   flip_addr,
  input  logic [WIDTH-1:0]           flip_mask,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [WIDTH-1:0]           rd_data,
  output logic [WIDTH-1:0]           tap_data,
  input  logic                       clr_start,
  output logic                       clr_busy,
  output logic                       clr_done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_LIM = DEPTH[AW:0];

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [AW-1:0]     ptr;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic              wr_ok;
  logic              flip_ok;
  logic              rd_ok;

  assign wr_ok = wr_en && ({1'b0, wr_addr} < DEPTH_LIM) && !clr_busy;
  assign rd_ok = ({1'b0, rd_addr} < DEPTH_LIM);

`ifdef BF_WORD_MEM_FLIP_EN
  assign flip_ok = flip_en && ({1'b0, flip_addr} < DEPTH_LIM) && !clr_busy;
`else
  logic unused_flip;
  assign unused_flip = flip_en;
  assign flip_ok     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr_start) state_nxt = SWEEP;
      SWEEP:   if (ptr == AW'(DEPTH - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    clr_busy = 1'b0;
    clr_done = 1'b0;
    case (state)
      SWEEP:   clr_busy = 1'b1;
      DONE:    begin
        clr_busy = 1'b1;
        clr_done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (state == IDLE && clr_start) begin
      ptr <= '0;
    end else if (state == SWEEP) begin
      ptr <= ptr + 1'b1;
    end
  end

  // Clear has priority; a same-address write and flip merge into wr_data ^ flip_mask.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (state == SWEEP && ptr == AW'(i)) begin
          mem[i] <= '0;
        end else if (wr_ok && wr_addr == AW'(i)) begin
          mem[i] <= (flip_ok && flip_addr == AW'(i)) ? (wr_data ^ flip_mask) : wr_data;
        end else if (flip_ok && flip_addr == AW'(i)) begin
          mem[i] <= mem[i] ^ flip_mask;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= rd_ok ? mem[rd_addr] : '0;
    end
  end

  assign tap_data = mem[TAP_IDX];

endmodule

// File: tb/tb_bf_word_mem.sv
// Scoreboard bench for bf_word_mem: reads queue their expected data, a monitor compares rd_data.
// Expected flip results follow BF_WORD_MEM_FLIP_EN as passed to the compile.
module tb_bf_word_mem;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en, flip_en, clr_start;
  logic [3:0] wr_addr, flip_addr, rd_addr;
  logic [7:0] wr_data, flip_mask;
  logic [7:0] rd_data, tap_data;
  logic       clr_busy, clr_done;

  logic       s_wr_en;
  logic [3:0] s_wr_addr, s_rd_addr;
  logic [7:0] s_wr_data, s_rd_data, s_tap_data;
  logic       s_clr_busy, s_clr_done;

  typedef struct {
    string      name;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  logic rd_req     = 1'b0;
  logic rd_req_q;

`ifdef BF_WORD_MEM_FLIP_EN
  localparam bit FLIP = 1'b1;
`else
  localparam bit FLIP = 1'b0;
`endif

  always #5 clk = ~clk;

  bf_word_mem dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .flip_en(flip_en), .flip_addr(flip_addr), .flip_mask(flip_mask),
    .rd_addr(rd_addr), .rd_data(rd_data), .tap_data(tap_data),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  bf_word_mem #(.WIDTH(8), .DEPTH(12), .TAP_IDX(5)) small_dut (
    .clk(clk), .rst(rst),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .flip_en(1'b0), .flip_addr(4'd0), .flip_mask(8'd0),
    .rd_addr(s_rd_addr), .rd_data(s_rd_data), .tap_data(s_tap_data),
    .clr_start(1'b0), .clr_busy(s_clr_busy), .clr_done(s_clr_done)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) rd_req_q <= 1'b0;
    else      rd_req_q <= rd_req;
  end

  // Monitor: every cycle whose previous edge sampled a read request presents one result.
  always @(negedge clk) begin
    if (rd_req_q) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL sb_underflow: got 0x%0h, expected no pending read", rd_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_output(e.name, rd_data, e.val);
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_read(input logic [3:0] a, input logic [7:0] e, input string n);
    rd_addr = a;
    rd_req  = 1'b1;
    sb.push_back('{n, e});
    cycle();
    rd_req  = 1'b0;
  endtask

  task automatic apply_write(input logic [3:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cycle();
    wr_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int busy_cnt, done_at, done_cnt, saw;
    rst = 1'b0;
    wr_en = 0; wr_addr = 0; wr_data = 0;
    flip_en = 0; flip_addr = 0; flip_mask = 0;
    rd_addr = 0; clr_start = 0;
    s_wr_en = 0; s_wr_addr = 0; s_wr_data = 0; s_rd_addr = 0;
    repeat (3) cycle();
    check_output("rst_rd_data", rd_data, 0);
    check_output("rst_busy", clr_busy, 0);
    check_output("rst_done", clr_done, 0);
    check_output("rst_tap", tap_data, 0);

    // Release reset with a write already pending: it must land on the first edge.
    rst = 1'b1;
    apply_write(4'd5, 8'hA5);
    check_output("tap_after_write", tap_data, 8'hA5);
    apply_read(4'd5, 8'hA5, "read_addr5");

    wr_en = 1; wr_addr = 4'd3; wr_data = 8'h0F;
    flip_en = 1; flip_addr = 4'd3; flip_mask = 8'h3C;
    cycle();
    wr_en = 0; flip_en = 0;
    apply_read(4'd3, FLIP ? 8'h33 : 8'h0F, "write_flip_same");

    wr_en = 1; wr_addr = 4'd1; wr_data = 8'h01;
    flip_en = 1; flip_addr = 4'd2; flip_mask = 8'h80;
    cycle();
    wr_en = 0; flip_en = 0;
    apply_read(4'd1, 8'h01, "write_diff_addr");
    apply_read(4'd2, FLIP ? 8'h80 : 8'h00, "flip_diff_addr");

    flip_en = 1; flip_addr = 4'd5; flip_mask = 8'hFF;
    cycle();
    flip_en = 0;
    check_output("tap_after_flip", tap_data, FLIP ? 8'h5A : 8'hA5);

    apply_write(4'd7, 8'h11);
    wr_en = 1; wr_addr = 4'd7; wr_data = 8'h22;
    apply_read(4'd7, 8'h11, "rdw_old");
    wr_en = 0;
    apply_read(4'd7, 8'h22, "rdw_new");

    for (int i = 0; i < 16; i++) apply_write(4'(i), 8'hFF);
    check_output("tap_filled", tap_data, 8'hFF);

    // Hold writes and clr_start high while busy; both must be ignored.
    clr_start = 1'b1;
    cycle();
    clr_start = 1'b0;
    busy_cnt = 0; done_at = 0; done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (!clr_busy) begin
        wr_en = 0; clr_start = 0;
        break;
      end
      busy_cnt++;
      if (clr_done) begin
        done_cnt++;
        done_at = busy_cnt;
      end
      wr_en = 1; wr_addr = 4'd15; wr_data = 8'h77; clr_start = 1;
      cycle();
    end
    wr_en = 0; clr_start = 0;
    check_output("sweep_busy_cycles", busy_cnt, 17);
    check_output("sweep_done_at", done_at, 17);
    check_output("sweep_done_count", done_cnt, 1);
    check_output("tap_after_clear", tap_data, 0);
    for (int i = 0; i < 16; i++) apply_read(4'(i), 8'h00, $sformatf("cleared_%0d", i));

    apply_write(4'd9, 8'h99);
    apply_write(4'd5, 8'h5A);
    clr_start = 1'b1;
    cycle();
    clr_start = 1'b0;
    repeat (3) cycle();
    rst = 1'b0;
    #1;
    check_output("abort_busy", clr_busy, 0);
    check_output("abort_done", clr_done, 0);
    check_output("abort_tap", tap_data, 0);
    check_output("abort_rd_data", rd_data, 0);
    cycle();
    rst = 1'b1;
    saw = 0;
    for (int c = 0; c < 25; c++) begin
      if (clr_busy || clr_done) saw = 1;
      cycle();
    end
    check_output("no_done_after_abort", saw, 0);
    apply_read(4'd9, 8'h00, "abort_word9");

    s_wr_en = 1; s_wr_addr = 4'd1; s_wr_data = 8'h44;
    cycle();
    s_wr_addr = 4'd13; s_wr_data = 8'hEE;
    cycle();
    s_wr_en = 0;
    s_rd_addr = 4'd1;
    cycle();
    check_output("small_read1", s_rd_data, 8'h44);
    s_rd_addr = 4'd13;
    cycle();
    check_output("small_read13", s_rd_data, 0);
    for (int i = 0; i < 12; i++) begin
      s_rd_addr = 4'(i);
      cycle();
      check_output($sformatf("small_word_%0d", i), s_rd_data, (i == 1) ? 8'h44 : 8'h00);
    end
    check_output("small_tap", s_tap_data, 0);

    repeat (3) cycle();
    check_output("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bf_word_mem.md
BF_WORD_MEM -- requirements
Module: bf_word_mem

Interface
REQ-001 SHALL have parameter WIDTH, default 8, word width in bits (1..64).
REQ-002 SHALL have parameter DEPTH, default 16, number of words (2..1024); AW = clog2(DEPTH) derived locally.
REQ-003 SHALL have parameter TAP_IDX, default 5, index of the word driven on tap_data (0..DEPTH-1).
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 wr_en / wr_addr / wr_data  input  1 / AW / WIDTH  write request, address, data.
REQ-007 flip_en / flip_addr / flip_mask  input  1 / AW / WIDTH  bit-flip request: XOR mask into the addressed word.
REQ-008 rd_addr  input  AW  read address, sampled every cycle.
REQ-009 rd_data  output  WIDTH  registered read data.
REQ-010 tap_data  output  WIDTH  combinational view of word TAP_IDX.
REQ-011 clr_start  input  1  start a sequential clear of all words.
REQ-012 clr_busy  output  1  high while a clear sweep is in progress.
REQ-013 clr_done  output  1  one-cycle pulse when the sweep completes.

Function
REQ-014 Write SHALL update mem[wr_addr] <= wr_data at the clock edge when wr_en=1.
REQ-015 Flip SHALL update mem[flip_addr] <= mem[flip_addr] ^ flip_mask when flip_en=1.
REQ-016 Write and flip to the same address in the same cycle SHALL store wr_data ^ flip_mask; different addresses SHALL both take effect.
REQ-017 rd_data SHALL equal mem[rd_addr] one cycle after rd_addr is sampled; read-during-write to the same address SHALL return the old contents.
REQ-018 Addresses >= DEPTH SHALL leave memory unchanged on write or flip; reads of such addresses SHALL return 0.
REQ-019 Clear FSM states: IDLE, SWEEP, DONE.
REQ-020 IDLE -> SWEEP on clr_start=1; clear pointer loads 0.
REQ-021 In SWEEP, one word per cycle SHALL be zeroed at the pointer, and the pointer SHALL increment; after word DEPTH-1 the FSM SHALL go to DONE (DEPTH cycles in SWEEP).
REQ-022 DONE SHALL last one cycle with clr_done=1, then return to IDLE.
REQ-023 clr_busy SHALL be 1 in SWEEP and DONE, otherwise 0.
REQ-024 clr_start while clr_busy=1 SHALL be ignored.
REQ-025 While clr_busy=1, write and flip requests SHALL be ignored; reads SHALL remain functional.
REQ-026 tap_data SHALL reflect the current contents of word TAP_IDX with no register stage.

Reset
REQ-027 rst=0 SHALL, asynchronously: zero all DEPTH words, set rd_data=0, return FSM to IDLE, set clr_busy=0 and clr_done=0, and clear the pointer.
REQ-028 Reset asserted mid-sweep SHALL abort the sweep; no clr_done pulse SHALL follow reset deassertion.
REQ-029 The first write after reset deassertion SHALL be honoured on the first rising edge with rst=1.

Configuration
REQ-030 Macro BF_WORD_MEM_FLIP_EN defined: flip port functional per REQ-015/016.
REQ-031 Macro BF_WORD_MEM_FLIP_EN undefined: flip_en, flip_addr and flip_mask ports SHALL remain present but be ignored; memory updates SHALL come from write and clear only.

Verification
REQ-032 Reset, then write 0xA5 to addr 5; read addr 5 -> rd_data=0xA5 next cycle and tap_data=0xA5 immediately after the write edge.
REQ-033 Same cycle, write 0x0F and flip 0x3C to addr 3 (FLIP_EN defined) -> read returns 0x33; with FLIP_EN undefined -> 0x0F.
REQ-034 Fill all 16 words with 0xFF, pulse clr_start -> clr_busy high 17 cycles, clr_done pulse on the 17th, all words 0; writes issued during the sweep are discarded.
REQ-035 Write addr 7=0x11, then in the same cycle write 0x22 to addr 7 and read addr 7 -> rd_data=0x11, then 0x22 on the following read.
REQ-036 Start a sweep, assert rst at sweep cycle 4 -> all words 0, clr_busy=0 immediately, no clr_done after release.
REQ-037 DEPTH=12: write to addr 13 -> no word changes; read addr 13 -> rd_data=0.
